// File: rtl/market_data_pkg.sv
// rtl/market_data_pkg.sv - shared constants and types for the market data quote parser
package market_data_pkg;

  localparam logic [7:0] MSG_TYPE_QUOTE = 8'h51;
  localparam int HDR_TYPE_LSB = 24;
  localparam int HDR_LEN_LSB  = 16;
  localparam int HDR_SEQ_LSB  = 0;
  localparam int SEQ_W        = 16;
  localparam int MIN_LEN      = 4;

  typedef enum logic [2:0] {
    ST_HDR,
    ST_SYM,
    ST_PRICE,
    ST_QTY,
    ST_PAD
  } parse_state_t;

  // Widest possible record; narrower builds zero-extend into it.
  typedef struct packed {
    logic [31:0]      symbol;
    logic [31:0]      price;
    logic [31:0]      qty;
    logic [SEQ_W-1:0] seq;
  } md_record_t;

endpackage

// File: rtl/market_data_fifo.sv
// rtl/market_data_fifo.sv - sync FIFO with registered first-word-fall-through output
module market_data_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  input  logic             pop_ready,
  output logic [WIDTH-1:0] pop_data,
  output logic             pop_valid
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      mem_count;
  logic             pop;
  logic             load;

  // Occupancy counts the output register as well as the array.
  assign pop  = pop_valid && pop_ready;
  assign load = (mem_count != '0) && (!pop_valid || pop);
  assign full = (mem_count + {{AW{1'b0}}, pop_valid}) == FULL_CNT;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      mem_count <= '0;
      pop_data  <= '0;
      pop_valid <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      mem_count <= mem_count + {{AW{1'b0}}, push} - {{AW{1'b0}}, load};
      if (load) begin
        pop_data  <= mem[rd_ptr];
        pop_valid <= 1'b1;
        rd_ptr    <= rd_ptr + AW'(1);
      end else if (pop) begin
        pop_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/market_data_msg_parser.sv
// rtl/market_data_msg_parser.sv - framed quote parser feeding a record FIFO
// Define SEQ_CHECK_EN to enable sequence gap detection on pushed quotes.
module market_data_msg_parser
  import market_data_pkg::*;
#(
  parameter int SYM_W      = 16,
  parameter int PRICE_W    = 32,
  parameter int QTY_W      = 16,
  parameter int MAX_LEN    = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        data_in,
  input  logic               data_valid,
  input  logic               data_last,
  output logic               data_ready,
  output logic [SYM_W-1:0]   out_symbol,
  output logic [PRICE_W-1:0] out_price,
  output logic [QTY_W-1:0]   out_qty,
  output logic [SEQ_W-1:0]   out_seq,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               err_len,
  output logic [15:0]        drop_count,
  output logic               seq_gap
);

  localparam int REC_W = SYM_W + PRICE_W + QTY_W + SEQ_W;

  parse_state_t     state;
  parse_state_t     state_next;
  logic [7:0]       word_cnt;
  logic [7:0]       msg_type;
  logic [7:0]       msg_len;
  logic [SEQ_W-1:0] msg_seq;
  logic [SYM_W-1:0] sym_q;
  logic [PRICE_W-1:0] price_q;
  logic [QTY_W-1:0] qty_q;
  logic [QTY_W-1:0] qty_word;
  logic [8:0]       total;
  logic             accept;
  logic             msg_good;
  logic             push;
  logic             drop;
  logic             len_bad;
  logic             fifo_full;
  logic [REC_W-1:0] push_data;
  logic [REC_W-1:0] pop_data;

  assign data_ready = reset && !fifo_full;
  assign accept     = data_valid && data_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_HDR;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    push       = 1'b0;
    drop       = 1'b0;
    len_bad    = 1'b0;
    total      = {1'b0, word_cnt} + 9'd1;
    msg_good   = ((state == ST_QTY) || (state == ST_PAD)) &&
                 (total == {1'b0, msg_len}) &&
                 (total >= 9'(MIN_LEN)) && (total <= 9'(MAX_LEN));
    // A message ending on its quantity word has not latched qty yet.
    qty_word   = (state == ST_QTY) ? data_in[QTY_W-1:0] : qty_q;
    if (accept) begin
      if (data_last) begin
        state_next = ST_HDR;
        push       = msg_good && (msg_type == MSG_TYPE_QUOTE);
        drop       = !push;
        len_bad    = !msg_good;
      end else begin
        case (state)
          ST_HDR:   state_next = ST_SYM;
          ST_SYM:   state_next = ST_PRICE;
          ST_PRICE: state_next = ST_QTY;
          default:  state_next = ST_PAD;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_cnt   <= '0;
      msg_type   <= '0;
      msg_len    <= '0;
      msg_seq    <= '0;
      sym_q      <= '0;
      price_q    <= '0;
      qty_q      <= '0;
      err_len    <= 1'b0;
      drop_count <= '0;
    end else begin
      err_len <= len_bad;
      if (drop && (drop_count != 16'hFFFF)) begin
        drop_count <= drop_count + 16'd1;
      end
      if (accept) begin
        if (data_last) begin
          word_cnt <= '0;
        end else if (word_cnt != 8'hFF) begin
          word_cnt <= word_cnt + 8'd1;
        end
        case (state)
          ST_HDR: begin
            msg_type <= data_in[HDR_TYPE_LSB +: 8];
            msg_len  <= data_in[HDR_LEN_LSB +: 8];
            msg_seq  <= data_in[HDR_SEQ_LSB +: SEQ_W];
          end
          ST_SYM:   sym_q   <= data_in[SYM_W-1:0];
          ST_PRICE: price_q <= data_in[PRICE_W-1:0];
          ST_QTY:   qty_q   <= data_in[QTY_W-1:0];
          default: ;
        endcase
      end
    end
  end

  assign push_data = {sym_q, price_q, qty_word, msg_seq};

  market_data_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .full      (fifo_full),
    .pop_ready (out_ready),
    .pop_data  (pop_data),
    .pop_valid (out_valid)
  );

  assign {out_symbol, out_price, out_qty, out_seq} = pop_data;

`ifdef SEQ_CHECK_EN
  logic [SEQ_W-1:0] expected_seq;
  logic             first_msg;
  logic             seq_gap_q;

  // The first quote after reset only seeds the expected sequence.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      expected_seq <= '0;
      first_msg    <= 1'b1;
      seq_gap_q    <= 1'b0;
    end else begin
      seq_gap_q <= 1'b0;
      if (push) begin
        seq_gap_q    <= !first_msg && (msg_seq != expected_seq);
        expected_seq <= msg_seq + 16'd1;
        first_msg    <= 1'b0;
      end
    end
  end

  assign seq_gap = seq_gap_q;
`else
  assign seq_gap = 1'b0;
`endif

endmodule
